instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Parametrised successor to the single-cycle instruction memory: word-organised instruction RAM with a registered fetch port and a byte-serial program loader.
- Sits between the core's fetch stage and an external boot/debug byte stream.
- Software images are loaded at run time instead of being fixed in the source.
- Adds a fetch handshake, fault reporting for misaligned or out-of-range PCs, and a load/run state machine.

Parameters:
- ADDR_W, 32, fetch address width in bits.
- DEPTH_LOG2, 9, log2 of memory depth in 32-bit words (default 512 words = 2 KiB).
- NOP_WORD, 32'h00000013, word returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address (PC).
- fetch_ready  out  1  a fetch can be accepted this cycle.
- inst_valid  out  1  inst/inst_fault valid this cycle.
- inst  out  32  fetched instruction word.
- inst_fault  out  1  the accepted fetch was misaligned or out of range.
- ld_start  in  1  pulse: begin a new load at word 0.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program byte, little-endian order.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_done  in  1  pulse: end of image.
- ld_count  out  DEPTH_LOG2+1  words written since the last ld_start.
- ld_overflow  out  1  sticky: bytes were dropped because memory is full.

Behaviour:
- Reset values:
  - state=RUN, inst=NOP_WORD, inst_valid=0, inst_fault=0.
  - ld_count=0, ld_overflow=0; internal byte_cnt=0, wr_ptr=0.
  - Memory contents are NOT cleared by reset.
- States:
  - RUN: fetch_ready=1, ld_ready=0.
  - LOAD: fetch_ready=0, ld_ready=1.
  - PAD: single cycle; fetch_ready=0, ld_ready=0.
- Transitions:
  - ld_start in any state -> LOAD. Clears byte_cnt, wr_ptr, ld_count and ld_overflow; any partial word is discarded.
  - LOAD with ld_done and byte_cnt==0 (after counting any byte accepted in the same cycle) -> RUN.
  - LOAD with ld_done and byte_cnt!=0 -> PAD.
  - PAD writes the partial word with missing upper bytes zero-filled, increments wr_ptr and ld_count, then -> RUN.
  - ld_start and ld_done in the same cycle: ld_start wins.
  - ld_valid and ld_done in the same cycle: the byte is accepted first, then ld_done is evaluated.
- Fetch:
  - Accepted when fetch_req && fetch_ready.
  - Latency is exactly 1 cycle: inst_valid=1 on the following cycle.
  - Word index is fetch_addr[DEPTH_LOG2+1:2].
  - Fault when fetch_addr[1:0]!=0, or when any of fetch_addr[ADDR_W-1:DEPTH_LOG2+2] is nonzero. On fault: inst=NOP_WORD, inst_fault=1, memory is not read.
  - With no accepted fetch: inst_valid=0, inst_fault=0, inst holds its last value.
  - A fetch accepted in the cycle ld_start is asserted still completes normally on the next cycle.
- Load:
  - Each accepted byte goes to lane byte_cnt (lane 0 = bits 7:0).
  - When the 4th byte is accepted, the assembled word (including that byte) is written at wr_ptr in the same edge; wr_ptr++, ld_count++, byte_cnt=0.
  - Once ld_count==2**DEPTH_LOG2, further bytes are accepted (ld_ready stays 1) but discarded, and ld_overflow is set. ld_overflow stays set until ld_start or rst. wr_ptr never wraps.
  - PAD performs no write when memory is full.
  - Fetch and load never coincide, so there is no read/write collision.
- Reset mid-load: returns to RUN. Words already written are retained; the partial word is lost.

Test Plan:
- Load bytes 93,00,A0,00 then 13,01,40,01, then ld_done; fetch 0x0 then 0x4 -> ld_count=2, RUN on the next cycle; inst=0x00A00093 then 0x01400113, each one cycle after its request, inst_fault=0.
- Load 6 bytes 11,22,33,44,55,66 then ld_done -> one PAD cycle, ld_count=2; fetch 0x4 returns 0x00006655.
- Fetch 0x2 and 0x800 (DEPTH_LOG2=9) -> inst=0x00000013, inst_fault=1, inst_valid=1 one cycle later. Fetch 0x7FC -> no fault.
- Feed 2**DEPTH_LOG2*4+3 bytes -> ld_count=512, ld_overflow=1, last word unchanged. Then ld_start -> ld_overflow=0, ld_count=0.
- During LOAD, drive fetch_req=1 -> fetch_ready=0, inst_valid stays 0. Assert ld_start and ld_done together -> stays in LOAD with counters cleared.
- Assert rst after 2 bytes of word 3 -> state RUN, ld_count=0, inst_valid=0; fetch of words 0-2 returns the previously loaded data.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Word-organised instruction RAM with a registered one-cycle fetch port and a
// byte-serial little-endian program loader, sequenced by a RUN/LOAD/PAD machine.
//
// state | meaning
// RUN   | fetches accepted, loader idle
// LOAD  | bytes accepted and packed into words, fetch blocked
// PAD   | one cycle: zero-filled partial word written, then back to RUN
module instr_mem_loader #(
   parameter int          ADDR_W     = 32,
   parameter int          DEPTH_LOG2 = 9,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [ADDR_W-1:0]     fetch_addr,
   output logic                  fetch_ready,
   output logic                  inst_valid,
   output logic [31:0]           inst,
   output logic                  inst_fault,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   input  logic [7:0]            ld_byte,
   output logic                  ld_ready,
   input  logic                  ld_done,
   output logic [DEPTH_LOG2:0]   ld_count,
   output logic                  ld_overflow
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      LOAD = 2'd1,
      PAD  = 2'd2
   } state_t;

   state_t       state;
   logic [1:0]   byte_cnt;
   logic [23:0]  word_buf;
   logic [31:0]  mem [DEPTH];

   logic         mem_full;
   logic         byte_acc;
   logic [1:0]   byte_cnt_nxt;
   logic         mem_we;
   logic [31:0]  mem_wdata;
   logic         fetch_acc;
   logic         fetch_bad;

   assign fetch_ready = (state == RUN);
   assign ld_ready    = (state == LOAD);
   assign mem_full    = (ld_count == FULL_CNT);
   assign fetch_acc   = fetch_req && fetch_ready;
   assign fetch_bad   = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[ADDR_W-1:DEPTH_LOG2+2]);

   always_comb begin
      byte_acc     = (state == LOAD) && ld_valid && !ld_start;
      byte_cnt_nxt = byte_acc ? byte_cnt + 2'd1 : byte_cnt;
      mem_we       = 1'b0;
      mem_wdata    = {8'h00, word_buf};
      if (!ld_start && !mem_full) begin
         if (byte_acc && byte_cnt == 2'd3) begin
            mem_we    = 1'b1;
            mem_wdata = {ld_byte, word_buf};
         end else if (state == PAD) begin
            mem_we    = 1'b1;
         end
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[ld_count[DEPTH_LOG2-1:0]] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_valid <= 1'b0;
         inst_fault <= 1'b0;
         inst       <= NOP_WORD;
      end else if (fetch_acc) begin
         inst_valid <= 1'b1;
         inst_fault <= fetch_bad;
         inst       <= fetch_bad ? NOP_WORD : mem[fetch_addr[DEPTH_LOG2+1:2]];
      end else begin
         inst_valid <= 1'b0;
         inst_fault <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         byte_cnt    <= 2'd0;
         word_buf    <= 24'h0;
         ld_count    <= '0;
         ld_overflow <= 1'b0;
      end else if (ld_start) begin
         state       <= LOAD;
         byte_cnt    <= 2'd0;
         word_buf    <= 24'h0;
         ld_count    <= '0;
         ld_overflow <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (byte_acc) begin
                  byte_cnt <= byte_cnt_nxt;
                  if (mem_full) begin
                     ld_overflow <= 1'b1;
                  end else if (byte_cnt == 2'd3) begin
                     ld_count <= ld_count + CNT_ONE;
                     word_buf <= 24'h0;
                  end else begin
                     case (byte_cnt)
                        2'd0:    word_buf[7:0]   <= ld_byte;
                        2'd1:    word_buf[15:8]  <= ld_byte;
                        default: word_buf[23:16] <= ld_byte;
                     endcase
                  end
               end
               // A byte arriving with ld_done is counted before deciding on PAD.
               if (ld_done)
                  state <= (byte_cnt_nxt == 2'd0) ? RUN : PAD;
            end
            PAD: begin
               if (!mem_full)
                  ld_count <= ld_count + CNT_ONE;
               byte_cnt <= 2'd0;
               word_buf <= 24'h0;
               state    <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: fetch expectations are queued at issue
// time and a monitor pops them whenever inst_valid is seen.
module tb_instr_mem_loader;
   localparam int          ADDR_W = 32;
   localparam int          DL     = 9;
   localparam int          DEPTH  = 1 << DL;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fetch_req = 1'b0;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              fetch_ready;
   logic              inst_valid;
   logic [31:0]       inst;
   logic              inst_fault;
   logic              ld_start = 1'b0;
   logic              ld_valid = 1'b0;
   logic [7:0]        ld_byte = 8'h00;
   logic              ld_ready;
   logic              ld_done = 1'b0;
   logic [DL:0]       ld_count;
   logic              ld_overflow;

   instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DL), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .inst_valid(inst_valid), .inst(inst), .inst_fault(inst_fault),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
      .ld_done(ld_done), .ld_count(ld_count), .ld_overflow(ld_overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] inst;
      logic        fault;
      int unsigned due;
   } exp_t;
   exp_t sbq[$];

   // Reference model: image as words, bytes of the word being assembled.
   logic [31:0] ref_mem [DEPTH];
   int          ref_cnt = 0;
   int          nbytes = 0;
   logic        ref_ovf = 1'b0;
   logic [7:0]  cur[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (sbq.size() > 0 && sbq[0].due < cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_inst_valid actual=0 expected=1 (due cycle %0d)", mon_e.due);
         end
         if (inst_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_inst_valid actual=1 expected=0 (t=%0t)", $time);
            end else begin
               mon_e = sbq.pop_front();
               chk("fetch_latency", cyc, mon_e.due);
               chk("inst", inst, mon_e.inst);
               chk("inst_fault", {31'h0, inst_fault}, {31'h0, mon_e.fault});
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic void fetch_model(input logic [31:0] a, output logic [31:0] w, output logic f);
      if (a % 4 != 0 || a >= DEPTH * 4) begin
         w = NOP;
         f = 1'b1;
      end else begin
         w = ref_mem[a / 4];
         f = 1'b0;
      end
   endfunction

   task automatic issue_fetch(input logic [31:0] a, input logic [31:0] w, input logic f);
      exp_t e;
      e.inst  = w;
      e.fault = f;
      e.due   = cyc + 1;
      sbq.push_back(e);
      fetch_req  = 1'b1;
      fetch_addr = a;
   endtask

   task automatic fetch_chk(input logic [31:0] a, input logic [31:0] w, input logic f);
      issue_fetch(a, w, f);
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic fetch_ref(input logic [31:0] a);
      logic [31:0] w;
      logic        f;
      fetch_model(a, w, f);
      fetch_chk(a, w, f);
   endtask

   function automatic void model_start();
      ref_cnt = 0;
      nbytes  = 0;
      ref_ovf = 1'b0;
      cur.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      nbytes++;
      if (ref_cnt >= DEPTH) begin
         ref_ovf = 1'b1;
      end else begin
         cur.push_back(b);
         if (cur.size() == 4) begin
            ref_mem[ref_cnt] = {cur[3], cur[2], cur[1], cur[0]};
            ref_cnt++;
            cur.delete();
         end
      end
   endfunction

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      model_start();
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_byte  = b;
      tick();
      ld_valid = 1'b0;
      model_byte(b);
   endtask

   task automatic finish_load();
      logic [31:0] w;
      bit          pad;
      pad = (nbytes % 4) != 0;
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      if (pad) begin
         chk("pad_fetch_ready", {31'h0, fetch_ready}, 32'h0);
         chk("pad_ld_ready", {31'h0, ld_ready}, 32'h0);
         tick();
         if (ref_cnt < DEPTH) begin
            w = '0;
            foreach (cur[i]) w[8*i +: 8] = cur[i];
            ref_mem[ref_cnt] = w;
            ref_cnt++;
         end
         cur.delete();
      end
      chk("run_fetch_ready", {31'h0, fetch_ready}, 32'h1);
      chk("run_ld_ready", {31'h0, ld_ready}, 32'h0);
      chk("ld_count", 32'(ld_count), 32'(ref_cnt));
      chk("ld_overflow", {31'h0, ld_overflow}, {31'h0, ref_ovf});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  img1[8] = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01};
      logic [7:0]  img2[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [31:0] a;
      logic [31:0] w;
      logic        f;
      int          n;

      repeat (3) tick();
      chk("rst_inst", inst, NOP);
      chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst_fault", {31'h0, inst_fault}, 32'h0);
      chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
      chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
      chk("rst_ld_count", 32'(ld_count), 32'h0);
      chk("rst_ld_overflow", {31'h0, ld_overflow}, 32'h0);
      rst = 1'b0;
      tick();

      // Two full words, then fetch them back.
      start_load();
      chk("load_ld_ready", {31'h0, ld_ready}, 32'h1);
      chk("load_fetch_ready", {31'h0, fetch_ready}, 32'h0);
      foreach (img1[i]) send_byte(img1[i]);
      finish_load();
      chk("img1_ld_count", 32'(ld_count), 32'd2);
      fetch_chk(32'h0, 32'h00A0_0093, 1'b0);
      fetch_chk(32'h4, 32'h0140_0113, 1'b0);

      // Partial trailing word is zero-padded.
      start_load();
      foreach (img2[i]) send_byte(img2[i]);
      finish_load();
      chk("img2_ld_count", 32'(ld_count), 32'd2);
      fetch_chk(32'h4, 32'h0000_6655, 1'b0);
      fetch_chk(32'h0, 32'h4433_2211, 1'b0);

      // Faulting fetches.
      fetch_chk(32'h2, NOP, 1'b1);
      fetch_chk(32'h800, NOP, 1'b1);
      fetch_chk(32'h3, NOP, 1'b1);
      fetch_chk(32'h8000_0000, NOP, 1'b1);

      // Fetch requests are refused in LOAD; ld_start beats ld_done.
      start_load();
      send_byte(8'hAB);
      send_byte(8'hCD);
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      repeat (3) begin
         tick();
         chk("load_fetch_blocked", {31'h0, fetch_ready}, 32'h0);
         chk("load_no_inst_valid", {31'h0, inst_valid}, 32'h0);
      end
      fetch_req = 1'b0;
      ld_start  = 1'b1;
      ld_done   = 1'b1;
      tick();
      ld_start  = 1'b0;
      ld_done   = 1'b0;
      model_start();
      chk("start_done_ld_ready", {31'h0, ld_ready}, 32'h1);
      chk("start_done_ld_count", 32'(ld_count), 32'h0);
      finish_load();

      // Fetch accepted in the same cycle as ld_start still completes.
      fetch_model(32'h4, w, f);
      issue_fetch(32'h4, w, f);
      ld_start = 1'b1;
      tick();
      fetch_req = 1'b0;
      ld_start  = 1'b0;
      model_start();
      chk("fetch_start_ld_ready", {31'h0, ld_ready}, 32'h1);
      finish_load();

      // Randomised images and fetch mixes.
      repeat (6) begin
         start_load();
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'($urandom));
         end
         finish_load();
         repeat (10) begin
            case ($urandom_range(0, 3))
               0: a = $urandom;
               1: a = (32'($urandom_range(0, ref_cnt - 1)) << 2) | 32'($urandom_range(1, 3));
               default: a = 32'($urandom_range(0, ref_cnt - 1)) << 2;
            endcase
            fetch_ref(a);
            if ($urandom_range(0, 1) == 1) tick();
         end
      end

      // Reset in the middle of word 3 keeps words 0-2.
      start_load();
      for (int i = 0; i < 14; i++) send_byte(8'($urandom));
      rst = 1'b1;
      #1;
      chk("midrst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
      chk("midrst_ld_ready", {31'h0, ld_ready}, 32'h0);
      chk("midrst_ld_count", 32'(ld_count), 32'h0);
      chk("midrst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("midrst_inst", inst, NOP);
      tick();
      rst = 1'b0;
      model_start();
      tick();
      fetch_ref(32'h0);
      fetch_ref(32'h4);
      fetch_ref(32'h8);

      // Fill memory completely plus three extra bytes.
      start_load();
      for (int i = 0; i < DEPTH * 4 + 3; i++) send_byte(8'($urandom));
      chk("full_ld_count", 32'(ld_count), 32'(DEPTH));
      chk("full_ld_overflow", {31'h0, ld_overflow}, 32'h1);
      chk("full_ld_ready", {31'h0, ld_ready}, 32'h1);
      finish_load();
      fetch_ref(32'h7FC);
      fetch_ref(32'h800);
      fetch_ref(32'h0);
      start_load();
      chk("restart_ld_overflow", {31'h0, ld_overflow}, 32'h0);
      chk("restart_ld_count", 32'(ld_count), 32'h0);
      finish_load();
      fetch_ref(32'h7FC);

      repeat (3) tick();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
